div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU). It complements the single-cycle ALU, which covers add/shift/compare/MUL*, by taking the division operations off the combinational path. It sits beside the ALU in the EX stage: EX issues a request and stalls while `req_ready` is low or a response is pending. The unit uses a radix-2 restoring algorithm, one quotient bit per cycle, with single-cycle handling of the RISC-V special cases.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
package div_pkg;

  // funct3 encodings of the M-extension divide group (decode uses bits [1:0]).
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  // Iterations per normal operation, minus one (initial counter value).
  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Conditional two's-complement negation.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Handshakes: a request transfers on a rising edge with req_valid && req_ready;
// a response transfers on a rising edge with resp_valid && resp_ready. A
// presented response and its result are held unchanged until it transfers.
// flush or rst drop any in-flight operation or held response.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  // Partial remainder; it is always below the divisor magnitude, so the
  // XLEN+1-bit shifted value below covers the full compare range.
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dmag_q, dmag_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            resp_valid_q, resp_valid_d;

  // Request decode and operand conditioning.
  logic            is_signed, op_rem, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  // One restoring step.
  logic [XLEN:0]   shifted, rem_next;
  logic            fits;
  logic [XLEN-1:0] quo_next;

  assign req_ready  = (state_q == IDLE) && !flush && !rst;
  assign resp_valid = resp_valid_q;
  assign result     = result_q;
  assign dbg_state  = state_q;

  // Next-state and datapath logic for accept, iterate and hand-off.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dmag_d       = dmag_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    is_rem_d     = is_rem_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;

    is_signed = ~funct3[0];
    op_rem    = funct3[1];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_mag     = neg_if(a_neg, dividend);
    b_mag     = neg_if(b_neg, divisor);
    div_zero  = (divisor == '0);
    ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
                (divisor == '1);

    shifted  = {rem_q, quo_q[XLEN-1]};
    fits     = (shifted >= {1'b0, dmag_q});
    rem_next = fits ? (shifted - {1'b0, dmag_q}) : shifted;
    quo_next = {quo_q[XLEN-2:0], fits};

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (div_zero || ovf) begin
            // Special cases finish immediately without iterating.
            state_d      = DONE;
            resp_valid_d = 1'b1;
            if (div_zero) result_d = op_rem ? dividend : '1;
            else          result_d = op_rem ? '0 : dividend;
          end else begin
            state_d   = CALC;
            cnt_d     = LAST_ITER;
            rem_d     = '0;
            quo_d     = a_mag;
            dmag_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_rem_d  = op_rem;
          end
        end
      end
      CALC: begin
        rem_d = rem_next[XLEN-1:0];
        quo_d = quo_next;
        if (cnt_q == 5'd0) begin
          result_d     = is_rem_q ? neg_if(neg_rem_q, rem_next[XLEN-1:0])
                                  : neg_if(neg_quo_q, quo_next);
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    // Abort discards any in-flight operation or held response.
    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dmag_q       <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      is_rem_q     <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dmag_q       <= dmag_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      is_rem_q     <= is_rem_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: behavioural reference model, per-cycle
// compare process, directed test-plan cases and randomized operations.
module tb_div_unit;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]  funct3;
  logic [31:0] dividend, divisor, result;
  logic [1:0]  dbg_state;

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .dividend   (dividend),
    .divisor    (divisor),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rr_mode  = 0;   // 0: always ready, 1: random, 2: hold low
  bit          seen_valid = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (f3[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return f3[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: handshakes on the rising edge ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst || flush) begin
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        seen_valid = 0;
      end else begin
        if (resp_valid && resp_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          seen_valid = 0;
        end
        if (req_valid && req_ready) begin
          exp_q.push_back(ref_div(funct3, dividend, divisor));
          lat_q.push_back(is_special(funct3, dividend, divisor) ? 0 : 32);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- compare process: every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("req_ready", {31'd0, req_ready},
            {31'd0, (exp_q.size() == 0) && !flush && !rst});
      if (exp_q.size() == 0) begin
        check("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
        check("state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
      end else if (resp_valid) begin
        check("result", result, exp_q[0]);
        check("state_done", {30'd0, dbg_state}, {30'd0, DONE});
        if (!seen_valid) begin
          check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
          seen_valid = 1;
        end
      end else if ((cyc - acc_q[0]) > lat_q[0]) begin
        check("resp_late", {31'd0, resp_valid}, 32'd1);
      end
    end
  end

  // ---------------- response-ready driver ----------------
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b);
    bit ok;
    ok = 0;
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = f3;
    dividend  = a;
    divisor   = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (req_ready) ok = 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (exp_q.size() == 0) ok = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding (cycle %0d)",
               exp_q.size(), cyc);
    end
  endtask

  // Pin the model against a hand-computed value, then run it through the DUT.
  task automatic run_exp(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    check("model_pin", ref_div(f3, a, b), exp);
    send(f3, a, b);
    wait_idle();
  endtask

  function automatic logic [31:0] rand_operand(input bit is_divisor);
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return is_divisor ? 32'(-int'($urandom_range(1, 9))) : $urandom;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    funct3    = 3'd0;
    dividend  = 32'd0;
    divisor   = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Directed test-plan operations.
    run_exp(DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA);
    run_exp(REM,  32'd20,        32'hFFFF_FFFD, 32'h0000_0002);
    run_exp(DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF);
    run_exp(REMU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
    run_exp(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_exp(DIV,  32'd7,         32'd0,         32'hFFFF_FFFF);
    run_exp(REMU, 32'd7,         32'd0,         32'h0000_0007);
    run_exp(DIVU, 32'd0,         32'd0,         32'hFFFF_FFFF);
    run_exp(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_exp(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_exp(DIV,  32'h8000_0000, 32'd1,         32'h8000_0000);
    run_exp(REM,  32'hFFFF_FFFA, 32'd3,         32'h0000_0000);
    run_exp(3'b010, 32'd9,       32'd4,         32'h0000_0001);

    // Backpressure: response held for 5 cycles, then a new request follows.
    rr_mode = 2;
    send(DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 60 && !resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_result", result, 32'd333);
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rr_mode = 0;
    send(REMU, 32'd1000, 32'd7);
    wait_idle();
    check("model_pin", ref_div(REMU, 32'd1000, 32'd7), 32'd6);

    // Abort with flush at T+10, with a request presented alongside it.
    send(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    funct3    = DIVU;
    dividend  = 32'd5;
    divisor   = 32'd0;
    #1;
    check("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (40) @(negedge clk);
    run_exp(DIVU, 32'd100, 32'd7, 32'd14);

    // Same abort using rst.
    send(DIV, 32'hFFFF_FF00, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rst_abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    run_exp(DIVU, 32'd100, 32'd7, 32'd14);

    // flush with a request while idle: nothing is accepted.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    funct3    = DIV;
    dividend  = 32'd1;
    divisor   = 32'd0;
    #1;
    check("flush_idle_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized operations with random backpressure and occasional aborts.
    for (int n = 0; n < 150; n++) begin
      f3      = 3'($urandom);
      a       = rand_operand(0);
      b       = rand_operand(1);
      rr_mode = $urandom_range(0, 1);
      send(f3, a, b);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      wait_idle();
    end
    rr_mode = 0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
